// File: rtl/rmt_wrapper_top.sv
// Single-stage match-action block on a 512-bit AXI-Stream path.
// In-band UDP control packets (dport 0xF1F2) program a 16-entry exact-match
// table keyed on UDP destination port plus a per-entry action word. Data packets
// are forwarded only when the lowest matching entry's action has its forward
// bit set; all other packets, and every control packet, are dropped in full.
module rmt_wrapper_top #(
  parameter int          C_S_AXI_DATA_WIDTH   = 32,
  parameter int          C_S_AXI_ADDR_WIDTH   = 12,
  parameter logic [31:0] C_BASEADDR           = 32'h80000000,
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int          C_M_AXIS_DATA_WIDTH  = 512,
  parameter int          PHV_ADDR_WIDTH       = 4
) (
  input  logic                              clk,
  input  logic                              aresetn,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
);

  localparam int NumEntries = 2 ** PHV_ADDR_WIDTH;

  localparam logic [15:0] CfgPort   = 16'hF1F2;
  localparam logic [7:0]  ResMatch  = 8'h01;
  localparam logic [7:0]  ResAction = 8'h13;

  // Elaboration-time sanity checks; the AXI-Lite parameters are kept only for
  // drop-in compatibility with the wider system and have no port behind them.
  if (C_M_AXIS_DATA_WIDTH != C_S_AXIS_DATA_WIDTH) begin : g_width_check
    $error("rmt_wrapper_top: output data width must equal input data width");
  end
  if ((C_S_AXI_DATA_WIDTH != 32 && C_S_AXI_DATA_WIDTH != 64) || (C_S_AXI_ADDR_WIDTH <= 0) ||
      ((C_BASEADDR & ((32'd1 << C_S_AXI_ADDR_WIDTH) - 32'd1)) != 32'd0)) begin : g_axil_check
    $error("rmt_wrapper_top: reserved AXI-Lite parameters are inconsistent");
  end

  typedef enum logic [1:0] {
    StIdle,      // next accepted beat is the first beat of a packet
    StCfgEntry,  // next accepted beat is beat 1 of a config packet (carries entry word)
    StCfgDrain,  // remaining beats of a config packet
    StData       // remaining beats of a data packet, decision held in fwd_q
  } state_e;

  state_e state_q, state_d;

  logic                      beat_acc;
  logic                      is_ip_udp;
  logic                      is_cfg;
  logic [15:0]               dport;
  logic                      hit;
  logic [PHV_ADDR_WIDTH-1:0] hit_idx;
  logic                      fwd_now;
  logic                      fwd_beat;
  logic                      cfg_wr;
  logic [15:0]               entry_word;

  logic                      fwd_q;
  logic [7:0]                res_q;
  logic [PHV_ADDR_WIDTH-1:0] idx_q;

  logic                      match_valid_q [NumEntries];
  logic [15:0]               match_key_q   [NumEntries];
  // Only the forward bit (action bit 8) has a consumer, so only it is stored.
  logic                      act_fwd_q     [NumEntries];

  logic                      m_valid_q;

  assign s_axis_tready = !m_valid_q || m_axis_tready;
  assign beat_acc      = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = m_valid_q;

  // Header classification; only meaningful on a first beat.
  assign is_ip_udp = ({s_axis_tdata[8*12 +: 8], s_axis_tdata[8*13 +: 8]} == 16'h0800) &&
                     (s_axis_tdata[8*14 +: 8] == 8'h45) &&
                     (s_axis_tdata[8*23 +: 8] == 8'h11);
  assign dport      = {s_axis_tdata[8*36 +: 8], s_axis_tdata[8*37 +: 8]};
  assign is_cfg     = is_ip_udp && (dport == CfgPort);
  // Bytes 64/65 of the packet are bytes 0/1 of the second beat.
  assign entry_word = {s_axis_tdata[7:0], s_axis_tdata[15:8]};

  // Priority match: scan high to low so the lowest matching index is kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NumEntries - 1; i >= 0; i--) begin
      if (match_valid_q[i] && (match_key_q[i] == dport)) begin
        hit     = 1'b1;
        hit_idx = PHV_ADDR_WIDTH'(i);
      end
    end
  end

  // A key of 0xF1F2 must never forward a config packet, hence the !is_cfg term.
  assign fwd_now = is_ip_udp && !is_cfg && hit && act_fwd_q[hit_idx];

  // Parser state register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Parser next state, config write strobe and per-beat forward decision.
  always_comb begin
    state_d  = state_q;
    cfg_wr   = 1'b0;
    fwd_beat = 1'b0;
    unique case (state_q)
      StIdle: begin
        fwd_beat = fwd_now;
        if (beat_acc && !s_axis_tlast) begin
          state_d = is_cfg ? StCfgEntry : StData;
        end
      end
      StCfgEntry: begin
        if (beat_acc) begin
          cfg_wr  = 1'b1;
          state_d = s_axis_tlast ? StIdle : StCfgDrain;
        end
      end
      StCfgDrain: begin
        if (beat_acc && s_axis_tlast) begin
          state_d = StIdle;
        end
      end
      StData: begin
        fwd_beat = fwd_q;
        if (beat_acc && s_axis_tlast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Capture first-beat decision and config target for the rest of the packet.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      fwd_q <= 1'b0;
      res_q <= '0;
      idx_q <= '0;
    end else if (beat_acc && (state_q == StIdle)) begin
      fwd_q <= fwd_now;
      res_q <= s_axis_tdata[8*46 +: 8];
      idx_q <= s_axis_tdata[8*48 +: PHV_ADDR_WIDTH];
    end
  end

  // Match/action table writes from the entry beat of a config packet.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NumEntries; i++) begin
        match_valid_q[i] <= 1'b0;
        match_key_q[i]   <= '0;
        act_fwd_q[i]     <= 1'b0;
      end
    end else if (cfg_wr) begin
      if (res_q == ResMatch) begin
        match_valid_q[idx_q] <= 1'b1;
        match_key_q[idx_q]   <= entry_word;
      end else if (res_q == ResAction) begin
        act_fwd_q[idx_q]     <= entry_word[8];
      end
    end
  end

  // Single output register stage; holds while the sink stalls.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q    <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tuser <= '0;
      m_axis_tlast <= 1'b0;
    end else if (beat_acc && fwd_beat) begin
      m_valid_q    <= 1'b1;
      m_axis_tdata <= s_axis_tdata;
      m_axis_tkeep <= s_axis_tkeep;
      m_axis_tuser <= s_axis_tuser;
      m_axis_tlast <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_valid_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rmt_wrapper_top.sv
// Directed bench for rmt_wrapper_top: table programming, forward/drop,
// backpressure and mid-packet reset.
module tb_rmt_wrapper_top;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  always #5 clk = ~clk;

  rmt_wrapper_top dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  int total = 0;
  int bad   = 0;
  int vhigh = 0;  // cycles with m_axis_tvalid high
  int xfers = 0;  // completed output handshakes

  always @(posedge clk) begin
    if (m_axis_tvalid) vhigh <= vhigh + 1;
    if (m_axis_tvalid && m_axis_tready) xfers <= xfers + 1;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [31:0] s);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[32*i +: 32] = s + 32'(i) * 32'h01010101;
    return d;
  endfunction

  function automatic logic [511:0] hdr(input logic [15:0] etype, input logic [15:0] dp,
                                       input logic [7:0] res, input logic [7:0] idx,
                                       input logic [31:0] s);
    logic [511:0] d;
    d = pat(s);
    d[8*12 +: 8] = etype[15:8];
    d[8*13 +: 8] = etype[7:0];
    d[8*14 +: 8] = 8'h45;
    d[8*23 +: 8] = 8'h11;
    d[8*36 +: 8] = dp[15:8];
    d[8*37 +: 8] = dp[7:0];
    d[8*46 +: 8] = res;
    d[8*48 +: 8] = idx;
    return d;
  endfunction

  // One beat: drive at negedge, transfer at the next posedge, return 1 ns after it.
  task automatic send(input logic [511:0] d, input logic [63:0] k, input logic [127:0] u,
                      input logic l);
    int n = 0;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $error("FAIL send_timeout: s_axis_tready low for %0d cycles, want high", n);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic cfg(input logic [7:0] res, input logic [7:0] idx, input logic [7:0] b64,
                     input logic [7:0] b65, input int nb);
    logic [511:0] d;
    send(hdr(16'h0800, 16'hF1F2, res, idx, 32'hC0DE0000 | 32'(idx)), '1, 128'h0, nb == 1);
    if (nb >= 2) begin
      d = pat(32'h11112222);
      d[7:0]  = b64;
      d[15:8] = b65;
      send(d, '1, 128'h0, nb == 2);
    end
    if (nb >= 3) send(pat(32'h33334444), '1, 128'h0, 1'b1);
  endtask

  logic [511:0] d0, d1, d2;
  logic [127:0] u0, u1, u2;
  logic [63:0]  k1;
  int           v0, x0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvalid", 512'(m_axis_tvalid), 512'(0));
    chk("rst_mdata", m_axis_tdata, 512'(0));
    chk("rst_mkeep", 512'(m_axis_tkeep), 512'(0));
    chk("rst_muser", 512'(m_axis_tuser), 512'(0));
    chk("rst_mlast", 512'(m_axis_tlast), 512'(0));
    chk("rst_sready", 512'(s_axis_tready), 512'(1));
    @(negedge clk);
    aresetn = 1'b1;

    // Actions only, no match entries: data must never forward
    v0 = vhigh;
    cfg(8'h13, 8'd1, 8'h04, 8'h00, 2);
    cfg(8'h13, 8'd2, 8'h04, 8'h04, 2);
    cfg(8'h13, 8'd3, 8'h04, 8'h08, 2);
    cfg(8'h13, 8'd4, 8'h04, 8'h0C, 2);
    send(hdr(16'h0800, 16'h1000, 8'h0, 8'h0, 32'hDA7A0000), '1, 128'hABCD, 1'b1);
    repeat (1000) @(posedge clk);
    #1;
    chk("no_match_1000cyc", 512'(vhigh - v0), 512'(0));

    // Multi-beat config packets of assorted resource ids are all consumed
    v0 = vhigh;
    cfg(8'h00, 8'd5, 8'h01, 8'h00, 2);
    cfg(8'h05, 8'd6, 8'h01, 8'h00, 3);
    cfg(8'h01, 8'd7, 8'h30, 8'h00, 2);
    cfg(8'h02, 8'd8, 8'h01, 8'h00, 3);
    repeat (5) @(posedge clk);
    #1;
    chk("cfg_never_fwd", 512'(vhigh - v0), 512'(0));

    // Hit on idx 7 (key 0x3000) whose action is 0: dropped
    v0 = vhigh;
    send(hdr(16'h0800, 16'h3000, 8'h0, 8'h0, 32'h30000000), '1, 128'h1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("hit_no_fwd_bit", 512'(vhigh - v0), 512'(0));

    // Program idx 2: key 0x1000, forward; 2-beat packet passes through
    cfg(8'h01, 8'd2, 8'h10, 8'h00, 2);
    cfg(8'h13, 8'd2, 8'h01, 8'h00, 2);
    x0 = xfers;
    d0 = hdr(16'h0800, 16'h1000, 8'h0, 8'h0, 32'h5A5A0000);
    d1 = pat(32'h77770000);
    u0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    u1 = 128'hDEAD_BEEF;
    k1 = 64'h0000_0000_FFFF_FFFF;
    send(d0, '1, u0, 1'b0);
    chk("fwd_b0_valid", 512'(m_axis_tvalid), 512'(1));
    chk("fwd_b0_data", m_axis_tdata, d0);
    chk("fwd_b0_misc", 512'({m_axis_tkeep, m_axis_tuser, m_axis_tlast}),
        512'({64'hFFFF_FFFF_FFFF_FFFF, u0, 1'b0}));
    send(d1, k1, u1, 1'b1);
    chk("fwd_b1_valid", 512'(m_axis_tvalid), 512'(1));
    chk("fwd_b1_data", m_axis_tdata, d1);
    chk("fwd_b1_misc", 512'({m_axis_tkeep, m_axis_tuser, m_axis_tlast}),
        512'({k1, u1, 1'b1}));
    @(posedge clk);
    #1;
    chk("fwd_drained", 512'(m_axis_tvalid), 512'(0));
    chk("fwd_xfer_count", 512'(xfers - x0), 512'(2));

    // Miss on dport 0x1001, and non-IP EtherType: both dropped
    v0 = vhigh;
    send(hdr(16'h0800, 16'h1001, 8'h0, 8'h0, 32'h10010000), '1, 128'h2, 1'b0);
    send(pat(32'h10011001), '1, 128'h3, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("miss_dropped", 512'(vhigh - v0), 512'(0));
    v0 = vhigh;
    send(hdr(16'h0806, 16'h1000, 8'h0, 8'h0, 32'h08060000), '1, 128'h4, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("arp_dropped", 512'(vhigh - v0), 512'(0));

    // Backpressure: sink stalls 5 cycles with output full
    x0 = xfers;
    d0 = hdr(16'h0800, 16'h1000, 8'h0, 8'h0, 32'hB0B00000);
    d1 = pat(32'hB1B10000);
    d2 = pat(32'hB2B20000);
    u0 = 128'hA0; u1 = 128'hA1; u2 = 128'hA2;
    @(negedge clk);
    m_axis_tready = 1'b0;
    send(d0, '1, u0, 1'b0);
    @(negedge clk);
    s_axis_tdata  = d1;
    s_axis_tkeep  = '1;
    s_axis_tuser  = u1;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_sready_low", 512'(s_axis_tready), 512'(0));
      chk("bp_mvalid_hold", 512'(m_axis_tvalid), 512'(1));
      chk("bp_mdata_hold", m_axis_tdata, d0);
      @(negedge clk);
    end
    chk("bp_muser_hold", 512'(m_axis_tuser), 512'(u0));
    m_axis_tready = 1'b1;
    #1;
    chk("bp_sready_back", 512'(s_axis_tready), 512'(1));
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    chk("bp_b1_data", m_axis_tdata, d1);
    chk("bp_b1_user", 512'(m_axis_tuser), 512'(u1));
    send(d2, '1, u2, 1'b1);
    chk("bp_b2_data", m_axis_tdata, d2);
    chk("bp_b2_last", 512'(m_axis_tlast), 512'(1));
    @(posedge clk);
    #1;
    chk("bp_xfer_count", 512'(xfers - x0), 512'(3));
    chk("bp_drained", 512'(m_axis_tvalid), 512'(0));

    // Reset mid-packet
    send(hdr(16'h0800, 16'h1000, 8'h0, 8'h0, 32'hCAFE0000), '1, 128'h5, 1'b0);
    chk("pre_rst_fwd", 512'(m_axis_tvalid), 512'(1));
    #2;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_mvalid", 512'(m_axis_tvalid), 512'(0));
    chk("mid_rst_mdata", m_axis_tdata, 512'(0));
    @(negedge clk);
    aresetn = 1'b1;
    v0 = vhigh;
    send(hdr(16'h0800, 16'h1000, 8'h0, 8'h0, 32'hCAFE1111), '1, 128'h6, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tables_cleared", 512'(vhigh - v0), 512'(0));

    // Lowest matching index wins: idx 3 (no forward) shadows idx 5 (forward)
    cfg(8'h01, 8'd3, 8'h44, 8'h44, 2);
    cfg(8'h01, 8'd5, 8'h44, 8'h44, 2);
    cfg(8'h13, 8'd5, 8'h01, 8'h00, 2);
    v0 = vhigh;
    send(hdr(16'h0800, 16'h4444, 8'h0, 8'h0, 32'h44440000), '1, 128'h7, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("prio_low_idx_drop", 512'(vhigh - v0), 512'(0));
    cfg(8'h13, 8'd3, 8'h01, 8'hFF, 2);
    // Single-beat config packet carries no entry word: must not clear idx 3 action
    cfg(8'h13, 8'd3, 8'h00, 8'h00, 1);
    d0 = hdr(16'h0800, 16'h4444, 8'h0, 8'h0, 32'h44445555);
    send(d0, '1, 128'h8, 1'b1);
    chk("prio_fwd_valid", 512'(m_axis_tvalid), 512'(1));
    chk("prio_fwd_data", m_axis_tdata, d0);
    chk("prio_fwd_last", 512'(m_axis_tlast), 512'(1));
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rmt_wrapper_top.md
Name: rmt_wrapper_top

Overview:
- Simplified single-stage match-action (RMT-style) block on a 512-bit AXI-Stream packet path.
- In-band control packets (UDP to port 0xF1F2) program a small match table and action table. These packets are always consumed and never forwarded.
- Data packets are looked up by UDP destination port. A packet is forwarded only on a table hit whose action has the forward bit set; otherwise it is dropped in full.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, reserved AXI-Lite data width; no AXI-Lite port exists.
- C_S_AXI_ADDR_WIDTH, 12, reserved; unused.
- C_BASEADDR, 32'h80000000, reserved; unused.
- C_S_AXIS_DATA_WIDTH, 512, input tdata width; tkeep is width/8.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width (in and out).
- C_M_AXIS_DATA_WIDTH, 512, output tdata width; must equal input width.
- PHV_ADDR_WIDTH, 4, table index width; 2^PHV_ADDR_WIDTH entries (16).

Ports:
- clk  in  1  sole clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  512  packet data; byte n = tdata[8n+7:8n], byte 0 first on wire
- s_axis_tkeep  in  64  byte enables
- s_axis_tuser  in  128  sideband, passed through
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1
- m_axis_tdata  out  512
- m_axis_tkeep  out  64
- m_axis_tuser  out  128
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1

Behaviour:
- Reset: m_axis_tvalid=0, m_axis_tdata/tkeep/tuser/tlast=0, all match entries invalid, all actions 0, parser at packet start.
- Reset mid-packet aborts that packet. The next accepted beat is treated as a first beat.
- A beat transfers when s_axis_tvalid && s_axis_tready.
- s_axis_tready = !m_axis_tvalid || m_axis_tready (single output register stage).
- Multi-byte fields are in network order, e.g. dport = {byte36, byte37}.
- Classification on the first beat:
  - IP_UDP = {byte12,byte13}==0x0800 && byte14==0x45 && byte23==0x11.
  - Config = IP_UDP && dport==0xF1F2.
  - Data = everything else.
- Config packet fields:
  - Resource id = byte46; index = byte48[PHV_ADDR_WIDTH-1:0].
  - Entry word = {byte64, byte65}, i.e. the low 16 bits of beat 1 (second beat).
  - The write occurs when beat 1 is accepted. Packets with only one beat write nothing.
  - Resource 0x01: match[index] <= {valid=1, key=entry word}.
  - Resource 0x13: action[index] <= {byte64, byte65}.
  - Any other id: consumed, no effect.
  - All beats of a config packet are dropped.
- Data packet lookup:
  - If IP_UDP, key = dport; else the packet misses.
  - Hit = any valid entry with key == dport; the lowest matching index wins.
  - Forward iff hit && action[idx] bit 8 (byte64 bit 0) == 1; else drop.
  - The decision is made combinationally on the first beat and held in a flag for the remaining beats until tlast.
- Forwarded beats appear on m_axis one cycle after acceptance, with tdata/tkeep/tuser/tlast unchanged.
- Dropped beats are still accepted at full rate; m_axis_tvalid stays 0 for them.
- m_axis outputs hold stable while m_axis_tvalid && !m_axis_tready.
- Table writes are visible to any packet whose first beat is accepted in a later cycle.
- A single-beat packet (tlast on first beat) is handled completely on that beat.

Test Plan:
- Reset, then send 4 config packets (resource 0x13, index 1..4, entry bytes64/65 = 04/00, 04/04, 04/08, 04/0C). Then send a one-beat UDP data packet with dport 0x1000, tkeep all-ones. Required: m_axis_tvalid stays 0 for 1000 cycles.
- Config packets of 2 and 3 beats, with resource ids 0x00, 0x05, 0x01, 0x02 -> m_axis_tvalid never asserts during or after any of them.
- Write resource 0x01 index 2 with key 0x1000 and resource 0x13 index 2 with byte64=0x01. Send a 2-beat data packet with dport 0x1000 -> both beats appear 1 cycle later, identical data/keep/user, tlast on beat 2.
- Same table, data packet with dport 0x1001 -> dropped. Non-UDP (EtherType 0x0806) packet -> dropped.
- Forwarding packet with m_axis_tready=0 for 5 cycles -> s_axis_tready=0 while the output is full, no beat is lost or duplicated, outputs are held stable.
- Assert aresetn low mid-packet -> m_axis_tvalid=0 at once, tables are cleared, and a previously forwarding key now drops.
